transport_send_mc: RTL and testbench

Multi-channel, parametrised transport-layer packetizer for the telephony link. Buffers DATA_W-bit audio samples per channel and emits framed byte-serial packets on packetOut toward the physical/network layer. Each packet is a header byte, a payload and an XOR checksum byte. Adds control packets, round-robin channel arbitration, a flush command and byte-level backpressure.

---
 rtl/transport_pkg.sv | 29 ++
 rtl/sample_fifo.sv | 59 +++++
 rtl/transport_send_mc.sv | 214 +++++++++++++++++++++
 tb/tb_transport_send_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/transport_pkg.sv
// Shared encodings for the transport-layer packetizer: command codes,
// header type codes and the packet FSM state type.
package transport_pkg;

  localparam logic [1:0] CMD_CTRL   = 2'b01;
  localparam logic [1:0] CMD_STREAM = 2'b10;
  localparam logic [1:0] CMD_FLUSH  = 2'b11;

  localparam logic [1:0] TYPE_CTRL = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CKSUM   = 2'd3
  } state_t;

  // Data header: type code, 3-bit channel number, three zero bits.
  function automatic logic [7:0] data_hdr(input logic [2:0] ch);
    return {TYPE_DATA, ch, 3'b000};
  endfunction

  // Control header: type code followed by the captured 6-bit argument.
  function automatic logic [7:0] ctrl_hdr(input logic [5:0] arg);
    return {TYPE_CTRL, arg};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Per-channel sample FIFO: synchronous push/pop/clear, occupancy count.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_send_mc.sv
// Multi-channel transport packetizer: per-channel sample FIFOs, round-robin
// channel arbitration, control packets with priority, level flush and a
// byte-serial output with valid/ready backpressure.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   ST_IDLE    | no packet; arbitrate control / data, apply flush
//   ST_HDR     | header byte on packetOut
//   ST_PAYLOAD | data samples, MSB byte first, pop on last byte
//   ST_CKSUM   | XOR of all preceding bytes; back to IDLE on accept
module transport_send_mc
  import transport_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 8,
  parameter int PKT_SAMPLES = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cmd,
  input  logic [5:0]        ctrl_arg,
  input  logic [DATA_W-1:0] data,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              sendData,
  input  logic              byte_ready,
  output logic              sending,
  output logic [7:0]        packetOut,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow
);

  localparam int NB   = DATA_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int SI_W = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int IW   = CH_W + 1;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q;
  logic              ctrl_pend_q;
  logic [5:0]        ctrl_arg_q;
  logic              is_ctrl_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   rr_q;
  logic [BI_W-1:0]   byte_idx_q;
  logic [SI_W-1:0]   samp_idx_q;
  logic [7:0]        csum_q;
  logic [NUM_CH-1:0] overflow_q;

  logic [DATA_W-1:0] head   [NUM_CH];
  logic [CW-1:0]     count  [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] ready_ch;

  logic              req_edge;
  logic              ctrl_go;
  logic              data_go;
  logic              accept;
  logic              last_byte;
  logic              last_samp;
  logic              flush;
  logic              found;
  logic [CH_W-1:0]   sel_ch;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        pay_byte;

  assign req_edge  = (cmd == CMD_CTRL) && (cmd_q != CMD_CTRL);
  assign ctrl_go   = ctrl_pend_q || req_edge;
  assign data_go   = (cmd == CMD_STREAM) && found;
  assign accept    = sending && byte_ready;
  assign last_byte = (byte_idx_q == BI_W'(NB - 1));
  assign last_samp = (samp_idx_q == SI_W'(PKT_SAMPLES - 1));
  assign flush     = (state_q == ST_IDLE) && (cmd == CMD_FLUSH);
  assign busy      = (state_q != ST_IDLE) || ctrl_pend_q;
  assign overflow  = overflow_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Out-of-range ch_sel never matches any channel and is dropped silently.
    assign push[c]     = sendData && (ch_sel == CH_W'(c)) && !flush;
    assign pop[c]      = (state_q == ST_PAYLOAD) && accept && last_byte && (ch_q == CH_W'(c));
    assign ready_ch[c] = !empty[c] && (count[c] >= CW'(PKT_SAMPLES));

    sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (data),
      .dout  (head[c]),
      .count (count[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // Round-robin pick: first ready channel at or after rr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_q} + IW'(i);
      if (idx >= IW'(NUM_CH)) idx = idx - IW'(NUM_CH);
      if (!found && ready_ch[idx]) begin
        found  = 1'b1;
        sel_ch = idx[CH_W-1:0];
      end
    end
  end

  // Current payload byte: head sample of the served channel, MSB byte first.
  always_comb begin
    shifted  = head[ch_q] >> (8 * (NB - 1 - int'(byte_idx_q)));
    pay_byte = shifted[7:0];
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    sending   = 1'b0;
    packetOut = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_go || data_go) state_d = ST_HDR;
      end
      ST_HDR: begin
        sending   = 1'b1;
        packetOut = is_ctrl_q ? ctrl_hdr(ctrl_arg_q) : data_hdr(3'(ch_q));
        if (byte_ready) state_d = is_ctrl_q ? ST_CKSUM : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        sending   = 1'b1;
        packetOut = pay_byte;
        if (byte_ready && last_byte && last_samp) state_d = ST_CKSUM;
      end
      ST_CKSUM: begin
        sending   = 1'b1;
        packetOut = csum_q;
        if (byte_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command edge detect and control-request pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= 2'b00;
      ctrl_pend_q <= 1'b0;
    end else begin
      cmd_q <= cmd;
      if (state_q == ST_IDLE && ctrl_go) ctrl_pend_q <= 1'b0;
      else if (req_edge)                 ctrl_pend_q <= 1'b1;
    end
  end

  // Packet context: launch capture, byte/sample indices, running checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_arg_q <= '0;
      is_ctrl_q  <= 1'b0;
      ch_q       <= '0;
      rr_q       <= '0;
      byte_idx_q <= '0;
      samp_idx_q <= '0;
      csum_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      byte_idx_q <= '0;
      samp_idx_q <= '0;
      csum_q     <= '0;
      if (ctrl_go) begin
        is_ctrl_q  <= 1'b1;
        ctrl_arg_q <= ctrl_arg;
      end else if (data_go) begin
        is_ctrl_q <= 1'b0;
        ch_q      <= sel_ch;
        rr_q      <= (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
      end
    end else if (accept) begin
      csum_q <= csum_q ^ packetOut;
      if (state_q == ST_PAYLOAD) begin
        if (last_byte) begin
          byte_idx_q <= '0;
          samp_idx_q <= samp_idx_q + 1'b1;
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end
    end
  end

  // One-cycle overflow pulse for each dropped push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= '0;
    else        overflow_q <= push & full & ~pop;
  end

endmodule

// File: tb/tb_transport_send_mc.sv
// Scoreboard bench for transport_send_mc: stimulus pushes expected bytes,
// a negedge monitor pops and compares every accepted output byte.
module tb_transport_send_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [5:0]  ctrl_arg = 6'h00;
  logic [15:0] data = 16'h0000;
  logic [0:0]  ch_sel = 1'b0;
  logic        sendData = 1'b0;
  logic        byte_ready = 1'b1;
  logic        sending;
  logic [7:0]  packetOut;
  logic        busy;
  logic [1:0]  overflow;

  int checks = 0;
  int fails = 0;
  logic [7:0] sb [$];

  transport_send_mc #(
    .DATA_W(16), .NUM_CH(2), .DEPTH(8), .PKT_SAMPLES(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .ctrl_arg(ctrl_arg), .data(data),
    .ch_sel(ch_sel), .sendData(sendData), .byte_ready(byte_ready),
    .sending(sending), .packetOut(packetOut), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && sending && byte_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte got=%h expected=none", packetOut);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb.pop_front();
        if (packetOut !== exp_b) begin
          fails++;
          $display("FAIL byte got=%h expected=%h", packetOut, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic push_sample(input logic ch, input logic [15:0] v);
    sendData = 1'b1;
    ch_sel   = ch;
    data     = v;
    tick();
    sendData = 1'b0;
  endtask

  task automatic expect_pkt(input logic [7:0] hdr, input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3, input logic [7:0] ck);
    sb.push_back(hdr);
    sb.push_back(s0[15:8]); sb.push_back(s0[7:0]);
    sb.push_back(s1[15:8]); sb.push_back(s1[7:0]);
    sb.push_back(s2[15:8]); sb.push_back(s2[7:0]);
    sb.push_back(s3[15:8]); sb.push_back(s3[7:0]);
    sb.push_back(ck);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || sending) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (sb.size() == 0 && !sending), 1);
  endtask

  task automatic quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sending) seen = 1'b1;
    end
    check({name, "_quiet"}, seen, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_sending", sending, 0);
    check("rst_packetOut", packetOut, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 2'b00);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: control packet 0x45, 0x45
    cmd = 2'b01; ctrl_arg = 6'h05;
    sb.push_back(8'h45); sb.push_back(8'h45);
    check("t1_busy_before", busy, 0);
    tick();
    check("t1_busy_hdr", busy, 1);
    check("t1_hdr", packetOut, 8'h45);
    ctrl_arg = 6'h3F;
    tick();
    check("t1_busy_ck", busy, 1);
    tick();
    check("t1_busy_done", busy, 0);
    quiet("t1_hold01", 5);
    cmd = 2'b00;
    wait_drain("t1", 10);

    // 2: single data packet on ch0
    for (int i = 0; i < 4; i++) push_sample(1'b0, 16'h8000 + 16'(i));
    expect_pkt(8'h80, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 8'h80);
    cmd = 2'b10;
    wait_drain("t2", 30);
    quiet("t2_empty", 10);
    cmd = 2'b00;

    // 3: ch0 then ch1 with a single IDLE gap (fresh round-robin pointer)
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_sample(1'b0, 16'hA000 + 16'(i));
    push_sample(1'b1, 16'hB010); push_sample(1'b1, 16'hB020);
    push_sample(1'b1, 16'hB030); push_sample(1'b1, 16'hB040);
    expect_pkt(8'h80, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 8'h80);
    expect_pkt(8'h88, 16'hB010, 16'hB020, 16'hB030, 16'hB040, 8'hC8);
    cmd = 2'b10;
    tick();
    check("t3_hdr0", packetOut, 8'h80);
    for (int k = 2; k <= 11; k++) tick();
    check("t3_gap", sending, 0);
    tick();
    check("t3_hdr1_valid", sending, 1);
    check("t3_hdr1", packetOut, 8'h88);
    wait_drain("t3", 30);
    cmd = 2'b00;

    // 4: backpressure on payload byte 3
    push_sample(1'b0, 16'h1200); push_sample(1'b0, 16'h3400);
    push_sample(1'b0, 16'h5600); push_sample(1'b0, 16'h7800);
    expect_pkt(8'h80, 16'h1200, 16'h3400, 16'h5600, 16'h7800, 8'h88);
    cmd = 2'b10;
    for (int k = 1; k <= 5; k++) tick();
    byte_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_sending", sending, 1);
      check("t4_stall_byte", packetOut, 8'h00);
      if (k < 2) tick();
    end
    tick();
    byte_ready = 1'b1;
    wait_drain("t4", 30);
    cmd = 2'b00;

    // 5: overflow on 9th push, packet of samples 1..4, then flush
    for (int i = 1; i <= 9; i++) begin
      sendData = 1'b1; ch_sel = 1'b1; data = 16'h1000 + 16'(i);
      tick();
      check("t5_overflow", overflow, (i == 9) ? 2'b10 : 2'b00);
    end
    sendData = 1'b0;
    tick();
    check("t5_overflow_pulse", overflow, 2'b00);
    expect_pkt(8'h88, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 8'h8C);
    cmd = 2'b10;
    tick();
    cmd = 2'b00;
    wait_drain("t5", 30);
    cmd = 2'b11;
    tick();
    cmd = 2'b10;
    quiet("t5_flushed", 20);
    cmd = 2'b00;

    // 6: reset mid-payload
    for (int i = 0; i < 4; i++) push_sample(1'b0, 16'h2000 + 16'(i));
    expect_pkt(8'h80, 16'h2000, 16'h2001, 16'h2002, 16'h2003, 8'h80);
    cmd = 2'b10;
    for (int k = 1; k <= 4; k++) tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_sending", sending, 0);
    check("t6_busy", busy, 0);
    check("t6_packetOut", packetOut, 8'h00);
    sb.delete();
    tick(); tick();
    reset = 1'b1;
    quiet("t6_no_resume", 15);
    expect_pkt(8'h80, 16'h3000, 16'h3001, 16'h3002, 16'h3003, 8'h80);
    for (int i = 0; i < 4; i++) push_sample(1'b0, 16'h3000 + 16'(i));
    wait_drain("t6", 30);
    cmd = 2'b00;
    tick();

    check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
